// File: rtl/data_bus_io_pkg.sv
// Shared definitions for the data-side bus slave: the address map,
// the UART transmitter state encoding and the UART status bit positions.
package data_bus_io_pkg;

  localparam logic [31:0] RAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] GPIO_ADDR  = 32'h1000_0000;
  localparam logic [31:0] UART_ADDR  = 32'h1000_0004;
  localparam logic [31:0] TIMER_ADDR = 32'h1000_0008;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int BUSY_BIT = 0;
  localparam int OVF_BIT  = 1;

endpackage

// File: rtl/data_bus_io_uart_tx.sv
// 8N1 serial transmitter.
// Ports: clk_i/rst_i (sync, active-high), start_i (accepted only when idle),
//        data_i (byte to send), busy_o (frame in flight), tx_o (line, idle high).
//
// state | meaning
// IDLE  | line high, waiting for start_i
// START | start bit (low) for CLK_DIV cycles
// DATA  | 8 data bits LSB first, CLK_DIV cycles each
// STOP  | stop bit (high) for CLK_DIV cycles
module uart_tx
  import data_bus_io_pkg::*;
#(
  parameter int CLK_DIV = 434
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       busy_o,
  output logic       tx_o
);

  localparam int BAUD_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);

  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        data_q, data_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    tx_o    = 1'b1;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = START;
          baud_d  = BAUD_RELOAD;
          data_d  = data_i;
        end
      end
      START: begin
        tx_o = 1'b0;
        if (baud_q == '0) begin
          state_d = DATA;
          baud_d  = BAUD_RELOAD;
          bit_d   = '0;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      DATA: begin
        tx_o = data_q[bit_q];
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_q == '0) state_d = IDLE;
        else              baud_d  = baud_q - BAUD_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o = (state_q != IDLE);

endmodule

// File: rtl/data_bus_io.sv
// Data-side memory-mapped slave for the single-cycle core: word RAM, GPIO
// output register, free-running timer and UART transmitter.
// Ports: clk_i/rst_i (sync, active-high); mem_we_i/mem_addr_i/mem_wdata_i
//        from the core; mem_rdata_o combinational load data; gpio_o;
//        uart_tx_o serial line; bus_err_o one-cycle pulse after a write to
//        an unmapped address.
module data_bus_io
  import data_bus_io_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAM_WORDS = 256,
  parameter int CLK_DIV   = 434,
  parameter int GPIO_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_we_i,
  input  logic [XLEN-1:0]   mem_addr_i,
  input  logic [XLEN-1:0]   mem_wdata_i,
  output logic [XLEN-1:0]   mem_rdata_o,
  output logic [GPIO_W-1:0] gpio_o,
  output logic              uart_tx_o,
  output logic              bus_err_o
);

  localparam int AW = $clog2(RAM_WORDS);

  // Byte offset is ignored; all decode works on the word address.
  logic [XLEN-1:0] word_addr;
  logic            unused_addr_bits;
  assign word_addr        = {mem_addr_i[XLEN-1:2], 2'b00};
  assign unused_addr_bits = ^mem_addr_i[1:0];

  logic sel_ram, sel_gpio, sel_uart, sel_timer, mapped;
  assign sel_ram   = (word_addr[XLEN-1:AW+2] == '0);
  assign sel_gpio  = (word_addr == XLEN'(GPIO_ADDR));
  assign sel_uart  = (word_addr == XLEN'(UART_ADDR));
  assign sel_timer = (word_addr == XLEN'(TIMER_ADDR));
  assign mapped    = sel_ram | sel_gpio | sel_uart | sel_timer;

  logic [XLEN-1:0]   ram_q [RAM_WORDS];
  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic [31:0]       timer_q, timer_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
  logic              uart_busy, uart_start;

  // A UART write while a frame is in flight never reaches the transmitter.
  assign uart_start = mem_we_i & sel_uart & ~uart_busy;

  always_comb begin
    gpio_d  = gpio_q;
    timer_d = timer_q + 32'd1;
    ovf_d   = ovf_q;
    err_d   = mem_we_i & ~mapped;
    if (mem_we_i) begin
      if (sel_gpio)  gpio_d  = mem_wdata_i[GPIO_W-1:0];
      if (sel_timer) timer_d = mem_wdata_i[31:0];
      if (sel_uart)  ovf_d   = uart_busy;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gpio_q  <= '0;
      timer_q <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      gpio_q  <= gpio_d;
      timer_q <= timer_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && mem_we_i && sel_ram) ram_q[mem_addr_i[AW+1:2]] <= mem_wdata_i;
  end

  uart_tx #(.CLK_DIV(CLK_DIV)) u_uart_tx (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(uart_start),
    .data_i (mem_wdata_i[7:0]),
    .busy_o (uart_busy),
    .tx_o   (uart_tx_o)
  );

  always_comb begin
    mem_rdata_o = '0;
    if (sel_ram) begin
      mem_rdata_o = ram_q[mem_addr_i[AW+1:2]];
    end else if (sel_gpio) begin
      mem_rdata_o = XLEN'(gpio_q);
    end else if (sel_uart) begin
      mem_rdata_o[BUSY_BIT] = uart_busy;
      mem_rdata_o[OVF_BIT]  = ovf_q;
    end else if (sel_timer) begin
      mem_rdata_o = XLEN'(timer_q);
    end
  end

  assign gpio_o    = gpio_q;
  assign bus_err_o = err_q;

endmodule
